uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single simulated-UART character channel (char/valid/busy) between NUM_REQ
//  character sources, e.g. the register-dump debug controller and the MMIO console writer.
//  Grants are line-atomic: a source keeps the channel until its end-of-line char is accepted,
//  so lines never interleave. Sits between the sources and the UART TX buffer; each source
//  sees the same char/valid/busy protocol it would see on a directly attached UART.
// PARAMETERS
//  NUM_REQ   2      number of requesters, 2..8
//  EOL_CHAR  8'h0d  char whose acceptance ends a line and releases the grant
//  TIMEOUT   1024   idle cycles while granted before forced release (UART_ARB_TIMEOUT_EN only)
// PORTS
//  clk              in   1          system clock, all logic on posedge
//  rst              in   1          synchronous, active-high reset
//  req_char         in   8*NUM_REQ  char from requester i at bits [8i+7:8i]
//  req_valid        in   NUM_REQ    requester i presents a char
//  req_busy         out  NUM_REQ    per-requester busy; requester i advances only when low
//  uart_busy        in   1          UART TX buffer cannot take a char this cycle
//  sim_uart_char    out  8          char forwarded to the UART
//  sim_uart_char_valid out 1        forwarded char valid
//  grant_onehot     out  NUM_REQ    current grant, one-hot, 0 when idle
//  grant_active     out  1          channel is owned
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst).
//  - Reset: state IDLE, grant_onehot=0, grant_active=0, req_busy=all 1, sim_uart_char=0,
//    sim_uart_char_valid=0, rr pointer=0 (requester 0 highest priority), timeout cnt=0.
//  - Accept: a char is transferred in a cycle where sim_uart_char_valid=1 (UART takes it then).
//  - States: IDLE, GRANT.
//    IDLE: if any req_valid, pick first valid index at/after rr pointer (wrapping), register
//      grant, go GRANT next cycle. 1-cycle latency from req_valid to grant_active.
//    GRANT(g): req_busy[g]=uart_busy; req_busy[others]=1.
//      sim_uart_char=req_char[g]; sim_uart_char_valid=req_valid[g] & ~uart_busy.
//      Accept of char==EOL_CHAR -> IDLE next cycle, rr pointer=(g+1) mod NUM_REQ.
//  - IDLE outputs: sim_uart_char=0, sim_uart_char_valid=0, req_busy=all 1.
//  - Granted source dropping req_valid mid-line: grant held (see timeout option).
//  - EOL accept while others request: one IDLE bubble cycle, then next by round-robin.
//  - Only granted requester's valid matters; others' chars are ignored, never forwarded.
//  - rst mid-line: grant dropped next edge, partial line abandoned, no char emitted that cycle.
//  - Outputs combinational from registered state + inputs; no char buffering.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: counter clears on grant and each accept, increments each
//   GRANT cycle without accept; on reaching TIMEOUT-1 state->IDLE, rr pointer advances
//   as for EOL. Undefined: no counter; grant held until EOL accepted.
// STRUCTURE
//  uart_arb_pkg: state encodings (S_IDLE, S_GRANT), default EOL_CHAR, grant index width.
//  Sub-module rr_pick: combinational round-robin pick (req vector, pointer -> onehot+index).
// TESTING
//  1 req0 sends "ab\r", uart_busy=0 -> grant 1 cycle after valid; 3 chars out, then IDLE.
//  2 req0,req1 valid same cycle after reset -> req0 first; after its 8'h0d req1 granted
//    after one bubble; req1 chars never interleave with req0 line.
//  3 uart_busy=1 for 5 cycles mid-line -> sim_uart_char_valid=0, req_busy[g]=1, char held,
//    resumes with same char after busy drops; no char lost or duplicated.
//  4 req1 drops valid mid-line, req0 valid -> grant stays req1; with UART_ARB_TIMEOUT_EN,
//    TIMEOUT=16: release after 16 idle cycles, req0 granted next.
//  5 rst asserted while granted -> next cycle grant_onehot=0, req_busy=all 1, valid=0.
//  6 NUM_REQ=3, all valid continuously -> grant order 0,1,2,0 line by line.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX line arbiter.
// Holds the FSM state encoding, the default end-of-line char and the grant index width helper.
package uart_arb_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } arb_state_t;

   localparam logic [7:0] DEFAULT_EOL_CHAR = 8'h0d;
   localparam int         MAX_REQ          = 8;

   function automatic int grant_idx_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Produces both a one-hot grant and its binary index; any flags a non-empty request vector.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      int j;
      j      = 0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-atomic round-robin arbiter sharing one UART char channel among NUM_REQ sources.
// Optional idle-grant timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int         NUM_REQ  = 2,
   parameter logic [7:0] EOL_CHAR = DEFAULT_EOL_CHAR,
   parameter int         TIMEOUT  = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*NUM_REQ-1:0] req_char,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_busy,
   input  logic                 uart_busy,
   output logic [7:0]           sim_uart_char,
   output logic                 sim_uart_char_valid,
   output logic [NUM_REQ-1:0]   grant_onehot,
   output logic                 grant_active
);

   localparam int IW = grant_idx_w(NUM_REQ);

   arb_state_t         state, state_n;
   logic [IW-1:0]      grant_idx, grant_idx_n;
   logic [IW-1:0]      rr_ptr, rr_ptr_n, next_ptr;
   logic [IW-1:0]      pick_idx;
   logic [NUM_REQ-1:0] grant_oh, grant_oh_n, pick_oh;
   logic               pick_any;
   logic               accept;
   logic               timed_out;
   logic [7:0]         cur_char;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign cur_char     = req_char[int'(grant_idx)*8 +: 8];
   assign next_ptr     = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IW'(1);
   assign accept       = sim_uart_char_valid;
   assign grant_onehot = grant_oh;
   assign grant_active = (state == S_GRANT);

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] idle_cnt;

   assign timed_out = (state == S_GRANT) && !accept && (idle_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || state != S_GRANT || accept || timed_out)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + CW'(1);
   end
`else
   assign timed_out = 1'b0;
`endif

   // Outputs are suppressed while rst is high so a reset mid-line neither emits nor consumes a char.
   always_comb begin
      sim_uart_char       = '0;
      sim_uart_char_valid = 1'b0;
      req_busy            = '1;
      if (state == S_GRANT && !rst) begin
         sim_uart_char       = cur_char;
         sim_uart_char_valid = req_valid[grant_idx] & ~uart_busy;
         req_busy[grant_idx] = uart_busy;
      end
   end

   always_comb begin
      state_n     = state;
      grant_idx_n = grant_idx;
      grant_oh_n  = grant_oh;
      rr_ptr_n    = rr_ptr;
      case (state)
         S_IDLE: begin
            if (pick_any) begin
               state_n     = S_GRANT;
               grant_idx_n = pick_idx;
               grant_oh_n  = pick_oh;
            end
         end
         S_GRANT: begin
            if ((accept && cur_char == EOL_CHAR) || timed_out) begin
               state_n    = S_IDLE;
               grant_oh_n = '0;
               rr_ptr_n   = next_ptr;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         grant_idx <= '0;
         grant_oh  <= '0;
         rr_ptr    <= '0;
      end else begin
         state     <= state_n;
         grant_idx <= grant_idx_n;
         grant_oh  <= grant_oh_n;
         rr_ptr    <= rr_ptr_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with three sources and a line-level reference model.
// Honours UART_ARB_TIMEOUT_EN in the model when the design is built with it.
module tb_uart_tx_arbiter;

   localparam int         N       = 3;
   localparam int         TIMEOUT = 16;
   localparam logic [7:0] EOL     = 8'h0d;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [8*N-1:0]   req_char = '0;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_busy;
   logic             uart_busy = 1'b0;
   logic [7:0]       sim_uart_char;
   logic             sim_uart_char_valid;
   logic [N-1:0]     grant_onehot;
   logic             grant_active;

   int tests = 0;
   int fails = 0;

   logic [7:0] txq  [N][$];
   logic [7:0] expq [N][$];
   int         valid_pct [N];
   int         busy_pct   = 0;
   bit         force_busy = 1'b0;
   bit         adv [N];

   int m_owner = -1;
   int m_ptr   = 0;
   int m_cnt   = 0;

   uart_tx_arbiter #(.NUM_REQ(N), .EOL_CHAR(EOL), .TIMEOUT(TIMEOUT)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .req_char            (req_char),
      .req_valid           (req_valid),
      .req_busy            (req_busy),
      .uart_busy           (uart_busy),
      .sim_uart_char       (sim_uart_char),
      .sim_uart_char_valid (sim_uart_char_valid),
      .grant_onehot        (grant_onehot),
      .grant_active        (grant_active)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         if (fails <= 40)
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic pushLine(input int i, input string s);
      for (int k = 0; k < s.len(); k++) begin
         txq[i].push_back(8'(s[k]));
         expq[i].push_back(8'(s[k]));
      end
      txq[i].push_back(EOL);
      expq[i].push_back(EOL);
   endtask

   task automatic pushRandomLine(input int i);
      int len;
      logic [7:0] c;
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
         c = 8'($urandom_range(32, 126));
         txq[i].push_back(c);
         expq[i].push_back(c);
      end
      txq[i].push_back(EOL);
      expq[i].push_back(EOL);
   endtask

   // Sources advance on the edge after a negedge where they saw valid && !busy.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (adv[i] && txq[i].size() > 0) void'(txq[i].pop_front());
         adv[i] = 1'b0;
         req_valid[i] = (txq[i].size() > 0) && (int'($urandom_range(99)) < valid_pct[i]);
         req_char[i*8 +: 8] = (txq[i].size() > 0) ? txq[i][0] : 8'($urandom);
      end
      uart_busy = force_busy || (int'($urandom_range(99)) < busy_pct);
   endtask

   task automatic runCycles(input int n);
      for (int c = 0; c < n; c++) applyStimulus();
   endtask

   task automatic releaseModel();
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_cnt   = 0;
   endtask

   // Reference: one owner at a time, lines pulled from per-source queues, round-robin on release.
   task automatic checkCycle();
      logic [N-1:0] exp_oh;
      logic [N-1:0] exp_busy;
      logic         exp_valid;
      logic [7:0]   exp_c;
      bit           found;
      exp_oh    = '0;
      exp_busy  = '1;
      exp_valid = 1'b0;
      exp_c     = 8'h00;
      found     = 1'b0;
      if (m_owner >= 0) begin
         exp_oh[m_owner] = 1'b1;
         if (!rst) begin
            exp_busy[m_owner] = uart_busy;
            exp_valid = req_valid[m_owner] && !uart_busy;
         end
      end
      checkOutput("grant_onehot", 32'(grant_onehot), 32'(exp_oh));
      checkOutput("grant_active", 32'(grant_active), 32'(m_owner >= 0));
      checkOutput("req_busy", 32'(req_busy), 32'(exp_busy));
      checkOutput("char_valid", 32'(sim_uart_char_valid), 32'(exp_valid));
      if (m_owner < 0) checkOutput("idle_char", 32'(sim_uart_char), 32'h0);
      for (int i = 0; i < N; i++) adv[i] = req_valid[i] && !req_busy[i];
      if (exp_valid) begin
         if (expq[m_owner].size() == 0) begin
            checkOutput("scoreboard_empty", 32'(sim_uart_char), 32'hffff_ffff);
         end else begin
            exp_c = expq[m_owner].pop_front();
            checkOutput("char", 32'(sim_uart_char), 32'(exp_c));
         end
      end
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_cnt   = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(m_ptr + k) % N]) begin
               found   = 1'b1;
               m_owner = (m_ptr + k) % N;
               m_cnt   = 0;
            end
         end
      end else begin
         if (exp_valid && exp_c == EOL) releaseModel();
`ifdef UART_ARB_TIMEOUT_EN
         else if (exp_valid) m_cnt = 0;
         else if (m_cnt == TIMEOUT - 1) releaseModel();
         else m_cnt++;
`endif
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         checkCycle();
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      for (int i = 0; i < N; i++) begin
         valid_pct[i] = 100;
         adv[i]       = 1'b0;
      end
      $display("[TB] reset phase");
      rst = 1'b1;
      runCycles(3);
      rst = 1'b0;

      $display("[TB] single line from source 0");
      pushLine(0, "ab");
      runCycles(10);

      $display("[TB] simultaneous lines from sources 0 and 1");
      pushLine(0, "first");
      pushLine(1, "second");
      runCycles(25);

      $display("[TB] uart busy mid-line");
      pushLine(0, "xyz");
      runCycles(2);
      force_busy = 1'b1;
      runCycles(5);
      force_busy = 1'b0;
      runCycles(8);

      $display("[TB] granted source stalls mid-line");
      pushLine(1, "hello");
      runCycles(3);
      valid_pct[1] = 0;
      pushLine(0, "q");
      runCycles(25);
      valid_pct[1] = 100;
      runCycles(15);

      $display("[TB] reset while granted");
      pushLine(2, "resetline");
      runCycles(4);
      rst = 1'b1;
      runCycles(1);
      rst = 1'b0;
      runCycles(15);

      $display("[TB] all sources continuously requesting");
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++) pushRandomLine(i);
      runCycles(80);

      $display("[TB] randomized traffic");
      for (int i = 0; i < N; i++) valid_pct[i] = $urandom_range(50, 100);
      busy_pct = 25;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++)
            if (txq[i].size() < 3 && $urandom_range(3) == 0) pushRandomLine(i);
         applyStimulus();
      end

      $display("[TB] drain");
      for (int i = 0; i < N; i++) valid_pct[i] = 100;
      busy_pct = 0;
      guard = 0;
      while ((txq[0].size() + txq[1].size() + txq[2].size()) != 0 && guard < 400) begin
         applyStimulus();
         guard++;
      end
      runCycles(4);
      for (int i = 0; i < N; i++) begin
         checkOutput("drain_tx", 32'(txq[i].size()), 32'h0);
         checkOutput("drain_scoreboard", 32'(expq[i].size()), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
